// File: rtl/alu_mac_client_pkg.sv
// Shared ALU configuration: field widths, opcodes and the request bundle
// presented to the key arbiter.
package alu_mac_client_pkg;

   localparam int KEY_SIZE     = 8;
   localparam int OPCODE_SIZE  = 4;
   localparam int OPERAND_SIZE = 32;

   typedef enum logic [OPCODE_SIZE-1:0] {
      ALU_NOP = 4'h0,
      ALU_ADD = 4'h1,
      ALU_SUB = 4'h2,
      ALU_MUL = 4'h3
   } alu_op_e;

   typedef struct packed {
      logic [KEY_SIZE-1:0]     key;
      alu_op_e                 op;
      logic [OPERAND_SIZE-1:0] a;
      logic [OPERAND_SIZE-1:0] b;
   } alu_req_t;

   // A zero key means "no request", so every other field collapses to zero with it.
   function automatic alu_req_t alu_req(input logic [KEY_SIZE-1:0]     key,
                                        input alu_op_e                 op,
                                        input logic [OPERAND_SIZE-1:0] a,
                                        input logic [OPERAND_SIZE-1:0] b);
      alu_req_t r;
      r = '0;
      if (key != '0) begin
         r.key = key;
         r.op  = op;
         r.a   = a;
         r.b   = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_mac_client.sv
// Y = A*B + C client of a shared, key-arbitrated ALU: issues a MUL request, then an
// ADD request carrying the product, and reports done_o or a timeout abort on err_o.
module alu_mac_client
   import alu_mac_client_pkg::*;
#(
   parameter logic [KEY_SIZE-1:0] KEY     = 8'h06,
   parameter int                  TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [OPERAND_SIZE-1:0] A_i,
   input  logic [OPERAND_SIZE-1:0] B_i,
   input  logic [OPERAND_SIZE-1:0] C_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic [OPERAND_SIZE-1:0] Y_o,
   output logic [OPCODE_SIZE-1:0]  op_o,
   output logic [KEY_SIZE-1:0]     key_o,
   output logic [OPERAND_SIZE-1:0] A_o,
   output logic [OPERAND_SIZE-1:0] B_o,
   input  logic [KEY_SIZE-1:0]     alu_key_i,
   input  logic [OPERAND_SIZE-1:0] alu_O_i
);

   typedef enum logic [1:0] {IDLE, MUL_REQ, ADD_REQ, DONE} state_e;

   localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e                  state_q, state_d;
   alu_req_t                req_q, req_d;   // latched A/B during MUL_REQ, product/C during ADD_REQ
   logic [OPERAND_SIZE-1:0] c_q, c_d;
   logic [OPERAND_SIZE-1:0] y_q, y_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic key_hit;
   logic wait_expired;

   assign key_hit      = (alu_key_i == KEY);
   // A matching result on the final waiting cycle is accepted rather than timed out.
   assign wait_expired = !key_hit && (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every _d signal takes its hold value first, so no branch can infer a latch.
      state_d = state_q;
      req_d   = req_q;
      c_d     = c_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               c_d     = C_i;
               cnt_d   = '0;
               busy_d  = 1'b1;
               req_d   = alu_req(KEY, ALU_MUL, A_i, B_i);
               state_d = MUL_REQ;
            end
         end

         MUL_REQ, ADD_REQ: begin
            if (key_hit) begin
               cnt_d = '0;
               if (state_q == MUL_REQ) begin
                  req_d   = alu_req(KEY, ALU_ADD, alu_O_i, c_q);
                  state_d = ADD_REQ;
               end else begin
                  y_d     = alu_O_i;
                  req_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end else if (wait_expired) begin
               cnt_d   = '0;
               req_d   = '0;
               busy_d  = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only; all next-state logic lives above.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         c_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         c_q     <= c_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;
   assign Y_o    = y_q;
   assign key_o  = req_q.key;
   assign op_o   = req_q.op;
   assign A_o    = req_q.a;
   assign B_o    = req_q.b;

endmodule
